// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter slice.
//   own_state_t        : ownership FSM encoding (FREE / OWN0 / OWN1)
//   DATA_MEM_SIZE      : highest legal word index of data_memory
//   MEM_DEPTH_DEFAULT  : number of words, always DATA_MEM_SIZE + 1
//   REQ0 / REQ1        : requester indices as stored in last_gnt
package mem_arb_pkg;

    localparam int unsigned DATA_MEM_SIZE     = 250;
    localparam int unsigned MEM_DEPTH_DEFAULT = DATA_MEM_SIZE + 1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter.
//   reqN_valid/we/lock/addr/wdata : request from requester N
//   gntN                          : request accepted this cycle
//   rspN_valid/err/rdata          : response, one cycle after gntN
// master = requesters, slave = arbiter.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic              req0_lock;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0]       req0_wdata;
    logic              req1_valid;
    logic              req1_we;
    logic              req1_lock;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0]       req1_wdata;

    logic              gnt0;
    logic              gnt1;
    logic              rsp0_valid;
    logic              rsp0_err;
    logic [31:0]       rsp0_rdata;
    logic              rsp1_valid;
    logic              rsp1_err;
    logic [31:0]       rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  gnt0, gnt1,
        input  rsp0_valid, rsp0_err, rsp0_rdata,
        input  rsp1_valid, rsp1_err, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output gnt0, gnt1,
        output rsp0_valid, rsp0_err, rsp0_rdata,
        output rsp1_valid, rsp1_err, rsp1_rdata
    );

endinterface

// File: rtl/data_memory.sv
// Single-ported word memory shared through data_mem_arbiter.
//   clk             : write clock
//   mem_access_addr : word address; out-of-range addresses are ignored
//   mem_write_data  : write data, committed on the rising edge
//   mem_write_en    : write strobe
//   mem_read_en     : read strobe
//   mem_read_data   : combinational read data (0 when not reading)
module data_memory #(
    parameter int unsigned DEPTH = mem_arb_pkg::MEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic [31:0] mem_access_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [31:0] mem_read_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [31:0]      ram [DEPTH];
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign in_range = mem_access_addr < 32'(DEPTH);
    assign idx      = mem_access_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (mem_write_en && in_range) begin
            ram[idx] <= mem_write_data;
        end
    end

    assign mem_read_data = (mem_read_en && in_range) ? ram[idx] : '0;

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of data_memory.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : requester 0 (CPU) and requester 1 (loader/debug)
//   mem_access_addr, mem_write_data, mem_write_en, mem_read_en : memory drive
//   mem_read_data    : combinational read data from memory
// One access per cycle; grants are combinational, responses registered.
// A granted locked access keeps ownership for up to LOCK_MAX grants.
module data_mem_arbiter #(
    parameter int unsigned MEM_DEPTH = mem_arb_pkg::MEM_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LOCK_MAX  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   bus,
    output logic [31:0]         mem_access_addr,
    output logic [31:0]         mem_write_data,
    output logic                mem_write_en,
    output logic                mem_read_en,
    input  logic [31:0]         mem_read_data
);

    import mem_arb_pkg::*;

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    own_state_t       state, state_nxt;
    logic             last_gnt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

    logic              gnt0, gnt1;
    logic              granted;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              in_range;
    logic              access_ok;
    logic              at_max;

    logic              rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0]       rsp0_rdata, rsp1_rdata;

    // The grant that makes the count reach LOCK_MAX is honoured but ends ownership.
    assign at_max = (32'(lock_cnt) + 32'd1) >= LOCK_MAX;

    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;

        // No grants while reset is held so memory drive stays quiet.
        if (rst_n) begin
            case (state)
                FREE: begin
                    gnt0 = bus.req0_valid && (!bus.req1_valid || last_gnt == REQ1);
                    gnt1 = bus.req1_valid && (!bus.req0_valid || last_gnt == REQ0);
                end
                OWN0:    gnt0 = bus.req0_valid;
                OWN1:    gnt1 = bus.req1_valid;
                default: ;
            endcase
        end

        case (state)
            FREE: begin
                if (gnt0 && bus.req0_lock && LOCK_MAX > 1) begin
                    state_nxt    = OWN0;
                    lock_cnt_nxt = CNT_W'(1);
                end else if (gnt1 && bus.req1_lock && LOCK_MAX > 1) begin
                    state_nxt    = OWN1;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end
            OWN0: begin
                if (!bus.req0_valid || (gnt0 && (!bus.req0_lock || at_max))) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = '0;
                end else if (gnt0) begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            OWN1: begin
                if (!bus.req1_valid || (gnt1 && (!bus.req1_lock || at_max))) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = '0;
                end else if (gnt1) begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = FREE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    assign granted   = gnt0 || gnt1;
    assign sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    assign in_range  = sel_addr < ADDR_W'(MEM_DEPTH);
    assign access_ok = granted && in_range;

    assign mem_access_addr = access_ok ? 32'(sel_addr) : '0;
    assign mem_write_data  = access_ok ? sel_wdata     : '0;
    assign mem_write_en    = access_ok && sel_we;
    assign mem_read_en     = access_ok && !sel_we;

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FREE;
            last_gnt <= REQ1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (gnt0) begin
                last_gnt <= REQ0;
            end else if (gnt1) begin
                last_gnt <= REQ1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= gnt0;
            rsp0_err   <= gnt0 && !in_range;
            rsp0_rdata <= (gnt0 && in_range && !sel_we) ? mem_read_data : '0;
            rsp1_valid <= gnt1;
            rsp1_err   <= gnt1 && !in_range;
            rsp1_rdata <= (gnt1 && in_range && !sel_we) ? mem_read_data : '0;
        end
    end

    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp0_err   = rsp0_err;
    assign bus.rsp0_rdata = rsp0_rdata;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp1_err   = rsp1_err;
    assign bus.rsp1_rdata = rsp1_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter + data_memory: a directed vector table,
// hand-written reset sequences, and randomized traffic, all compared each
// cycle against a transaction-level model of ownership, memory and responses.
module tb_data_mem_arbiter;

    import mem_arb_pkg::*;

    localparam int unsigned DEPTH    = MEM_DEPTH_DEFAULT;
    localparam int unsigned LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read_en;

    data_mem_arbiter_if #(.ADDR_W(32)) bus ();

    data_mem_arbiter #(
        .MEM_DEPTH(DEPTH),
        .ADDR_W(32),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .mem_access_addr(mem_access_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data)
    );

    data_memory #(.DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .mem_access_addr(mem_access_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          we;
        bit          lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        r0;
        req_t        r1;
        bit          g0;
        bit          g1;
        bit          crsp;   // check the response selected below at this vector
        bit          rsel;
        bit          rerr;
        logic [31:0] rdata;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Model: memory image, owner (-1 = nobody), grants taken under the lock,
    // last granted requester, and the response due in the next cycle.
    logic [31:0] ram_m [DEPTH];
    int          owner;
    int          held;
    int          last;
    bit          pv   [2];
    bit          perr [2];
    logic [31:0] prd  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        held  = 0;
        last  = 1;
        for (int n = 0; n < 2; n++) begin
            pv[n]   = 1'b0;
            perr[n] = 1'b0;
            prd[n]  = '0;
        end
    endtask

    function automatic req_t R(input bit v, input bit we, input bit lock,
                               input logic [31:0] addr, input logic [31:0] wdata);
        req_t q;
        q.v = v; q.we = we; q.lock = lock; q.addr = addr; q.wdata = wdata;
        return q;
    endfunction

    function automatic vec_t V(input req_t a, input req_t b, input bit g0, input bit g1,
                               input bit c, input bit s, input bit e, input logic [31:0] d);
        vec_t t;
        t.r0 = a; t.r1 = b; t.g0 = g0; t.g1 = g1;
        t.crsp = c; t.rsel = s; t.rerr = e; t.rdata = d;
        return t;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input req_t r0, input req_t r1, input bit rst_v, output int g);
        req_t        r [2];
        bit          ok;
        logic [31:0] ea;
        r[0] = r0;
        r[1] = r1;
        @(negedge clk);
        rst_n          = rst_v;
        bus.req0_valid = r0.v;  bus.req0_we = r0.we;  bus.req0_lock = r0.lock;
        bus.req0_addr  = r0.addr; bus.req0_wdata = r0.wdata;
        bus.req1_valid = r1.v;  bus.req1_we = r1.we;  bus.req1_lock = r1.lock;
        bus.req1_addr  = r1.addr; bus.req1_wdata = r1.wdata;
        if (!rst_v) model_reset();
        #1;
        g = -1;
        if (rst_v) begin
            if (owner >= 0) begin
                if (r[owner].v) g = owner;
            end else if (r[0].v && r[1].v) begin
                g = 1 - last;
            end else if (r[0].v) begin
                g = 0;
            end else if (r[1].v) begin
                g = 1;
            end
        end
        ok = (g >= 0) && (r[(g >= 0) ? g : 0].addr < DEPTH);
        ea = ok ? r[g].addr : 32'd0;

        chk("gnt0", 32'(bus.gnt0), 32'(g == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(g == 1));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(pv[0]));
        chk("rsp0_err",   32'(bus.rsp0_err),   32'(perr[0]));
        chk("rsp0_rdata", bus.rsp0_rdata, prd[0]);
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(pv[1]));
        chk("rsp1_err",   32'(bus.rsp1_err),   32'(perr[1]));
        chk("rsp1_rdata", bus.rsp1_rdata, prd[1]);
        chk("mem_addr",   mem_access_addr, ea);
        chk("mem_wdata",  mem_write_data, ok ? r[g].wdata : 32'd0);
        chk("mem_we",     32'(mem_write_en), 32'(ok && r[g].we));
        chk("mem_re",     32'(mem_read_en),  32'(ok && !r[g].we));

        if (rst_v) begin
            for (int n = 0; n < 2; n++) begin
                pv[n]   = (g == n);
                perr[n] = (g == n) && !ok;
                prd[n]  = ((g == n) && ok && !r[n].we) ? ram_m[ea[7:0]] : 32'd0;
            end
            if (ok && r[g].we) ram_m[ea[7:0]] = r[g].wdata;
            if (owner < 0) begin
                if (g >= 0 && r[g].lock) begin
                    owner = g;
                    held  = 1;
                end
            end else if (!r[owner].v) begin
                owner = -1;
            end else if (g == owner) begin
                held++;
                if (!r[owner].lock || held >= LOCK_MAX) owner = -1;
            end
            if (g >= 0) last = g;
        end
    endtask

    function automatic req_t rand_req();
        return R(($urandom % 10) < 7, $urandom % 2, ($urandom % 4) == 0,
                 32'($urandom_range(0, 259)), $urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [$];
        req_t idle;
        req_t cur [2];
        int   g;

        idle = R(0, 0, 0, 0, 0);
        model_reset();

        // Reset: requests are ignored and nothing drives the memory.
        step(R(1, 0, 0, 5, 0), idle, 1'b0, g);
        step(R(1, 1, 0, 5, 32'h1111), R(1, 0, 0, 7, 0), 1'b0, g);

        // Loader fills the whole memory.
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(idle, R(1, 1, 0, 32'(i), $urandom), 1'b1, g);
        end

        tv.push_back(V(R(1,0,0,5,0), R(1,0,0,5,0), 1,0, 0,0,0,0));
        tv.push_back(V(idle,         R(1,0,0,5,0), 0,1, 0,0,0,0));
        for (int i = 0; i < 6; i++)
            tv.push_back(V(R(1,0,0,7,0), R(1,0,0,8,0), (i % 2) == 0, (i % 2) == 1, 0,0,0,0));
        tv.push_back(V(R(1,1,0,10,32'hDEADBEEF), idle, 1,0, 0,0,0,0));
        tv.push_back(V(R(1,0,0,10,0), idle, 1,0, 0,0,0,0));
        tv.push_back(V(idle, idle, 0,0, 1,0,0,32'hDEADBEEF));
        tv.push_back(V(idle, R(1,0,0,251,0), 0,1, 0,0,0,0));
        tv.push_back(V(idle, R(1,1,0,300,32'h12345678), 0,1, 1,1,1,0));
        tv.push_back(V(idle, idle, 0,0, 1,1,1,0));
        for (int i = 0; i < 5; i++)
            tv.push_back(V(R(1,0,1,3,0), R(1,0,0,4,0), i < 4, i == 4, 0,0,0,0));
        tv.push_back(V(idle, idle, 0,0, 0,0,0,0));
        tv.push_back(V(R(1,0,1,6,0), idle, 1,0, 0,0,0,0));
        tv.push_back(V(idle, R(1,0,0,6,0), 0,0, 0,0,0,0));
        tv.push_back(V(idle, R(1,0,0,6,0), 0,1, 0,0,0,0));
        tv.push_back(V(idle, idle, 0,0, 0,0,0,0));

        foreach (tv[i]) begin
            step(tv[i].r0, tv[i].r1, 1'b1, g);
            chk("tbl_gnt0", 32'(bus.gnt0), 32'(tv[i].g0));
            chk("tbl_gnt1", 32'(bus.gnt1), 32'(tv[i].g1));
            if (tv[i].crsp) begin
                chk("tbl_rsp_valid", 32'(tv[i].rsel ? bus.rsp1_valid : bus.rsp0_valid), 32'd1);
                chk("tbl_rsp_err",   32'(tv[i].rsel ? bus.rsp1_err   : bus.rsp0_err),   32'(tv[i].rerr));
                chk("tbl_rsp_rdata", tv[i].rsel ? bus.rsp1_rdata : bus.rsp0_rdata, tv[i].rdata);
            end
        end

        // Whole-memory readback: the out-of-range write must have touched nothing.
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(R(1, 0, 0, 32'(i), 0), idle, 1'b1, g);
        end
        step(idle, idle, 1'b1, g);

        // Reset during the cycle of a granted locked read.
        step(R(1, 0, 1, 5, 0), idle, 1'b1, g);
        chk("mid_gnt0", 32'(bus.gnt0), 32'd1);
        rst_n = 1'b0;
        model_reset();
        step(R(1, 0, 1, 5, 0), idle, 1'b0, g);
        chk("mid_rsp_dropped", 32'(bus.rsp0_valid), 32'd0);
        step(idle, idle, 1'b0, g);
        step(idle, R(1, 0, 0, 9, 0), 1'b1, g);
        chk("post_reset_unlocked_gnt1", 32'(bus.gnt1), 32'd1);
        step(idle, idle, 1'b1, g);
        step(R(1, 0, 0, 9, 0), R(1, 0, 0, 9, 0), 1'b1, g);
        chk("post_reset_gnt0", 32'(bus.gnt0), 32'd1);
        step(idle, idle, 1'b1, g);

        // Random traffic; each requester holds its request until granted.
        cur[0] = rand_req();
        cur[1] = rand_req();
        for (int c = 0; c < 3000; c++) begin
            step(cur[0], cur[1], 1'b1, g);
            for (int n = 0; n < 2; n++) begin
                if (g == n || !cur[n].v) cur[n] = rand_req();
            end
        end
        step(idle, idle, 1'b1, g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter in front of the single-ported `data_memory`. It shares the memory between requester 0 (CPU load/store stage) and requester 1 (test loader / debug port). It resolves contention each cycle using round-robin priority, with an optional bounded lock for atomic read-modify-write sequences. It range-checks word addresses and returns registered read data with a per-requester valid/error response.

## Interface
- `MEM_DEPTH`, 251: number of 32-bit words; legal addresses are 0..MEM_DEPTH-1.
- `ADDR_W`, 32: address width, word-indexed, matching `mem_access_addr`.
- `LOCK_MAX`, 4: maximum consecutive locked grants to one requester.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): access request.
- `reqN_we` in 1: 1 = write, 0 = read.
- `reqN_lock` in 1: keep ownership after this grant.
- `reqN_addr` in ADDR_W: word address.
- `reqN_wdata` in 32: write data.
- `gntN` out 1: request accepted this cycle.
- `rspN_valid` out 1: response for the access granted in the previous cycle.
- `rspN_err` out 1: that access was out of range.
- `rspN_rdata` out 32: read data; 0 for writes and errors.
- `mem_access_addr` out 32, `mem_write_data` out 32, `mem_write_en` out 1, `mem_read_en` out 1: memory drive.
- `mem_read_data` in 32: combinational read data from memory.

## Operation
- Exactly one access per cycle. `gntN` is combinational from the current inputs and state.
- **Round-robin:**
  - `last_gnt` register holds the most recently granted requester.
  - When both requesters are requesting and no lock is held, the requester other than `last_gnt` wins.
  - If only one requester is requesting, it wins.
- **Ownership FSM, states FREE / OWN0 / OWN1:**
  - FREE: arbitrate as above. Granting N with `reqN_lock`=1 moves to OWNN and sets `lock_cnt`=1.
  - OWNN: only N may be granted; the other requester's `gnt` stays 0 even if N is idle.
  - OWNN -> FREE when a granted cycle of N has lock=0, or when N drops `reqN_valid`.
  - OWNN -> FREE when `lock_cnt` reaches LOCK_MAX; that grant is honoured, but its lock is ignored.
  - In OWNN, a granted locked cycle increments `lock_cnt`.
- **Range check:** `reqN_addr` >= MEM_DEPTH is out of range.
  - Out-of-range requests are still granted.
  - `mem_write_en` and `mem_read_en` stay 0 for them.
  - The response has err=1 and rdata=0.
- **Memory drive:**
  - When idle or on an error, all memory outputs are 0.
  - On an in-range grant: `mem_access_addr` = `reqN_addr`, `mem_write_data` = `reqN_wdata`, `mem_write_en` = `reqN_we`, `mem_read_en` = !`reqN_we`.
- **Response:**
  - Registered; only the granted requester's `rsp` fires, one cycle after `gnt`.
  - Reads return the `mem_read_data` sampled at the grant edge.
  - Writes return valid=1 and rdata=0.

## Timing
- **Reset (asynchronous assert, synchronous release):**
  - State = FREE, `last_gnt` = 1 (requester 0 wins first), `lock_cnt` = 0.
  - All `rsp*` outputs = 0; memory-drive outputs = 0 while `rst_n`=0.
- **Latency:** `gnt` in cycle T; `rsp` in cycle T+1. Throughput is one access per cycle; back-to-back grants produce back-to-back responses.
- **Read-after-write (same address, consecutive cycles):** the read sees the new data, because the memory write commits at edge T.
- A requester must hold `req*`, `addr`, `we` and `wdata` stable until it sees `gnt`. The arbiter does not buffer requests.
- **Reset mid-operation:** a response pending at the assertion edge is dropped (no `rsp`), and any lock is released.
- **Simultaneous request and lock expiry:** on the LOCK_MAX-th grant, the next cycle is arbitrated in FREE. Because `last_gnt`=N, the other requester wins if it is requesting.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the FSM state encoding (FREE/OWN0/OWN1);
  - the `MEM_DEPTH` default, kept consistent with `data_mem_size`+1;
  - the requester index constants.
- Single module, no sub-modules.
- The bench instantiates `data_mem_arbiter` together with `data_memory`.

## Test plan
- **Reset and first grant:** reset, then both requesters read address 5 in the same cycle -> `gnt0`=1, `gnt1`=0; next cycle `rsp0_valid`=1 with `rsp0_rdata`=ram[5]; then `gnt1`=1.
- **Round-robin:** both requesters hold reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each response arrives one cycle after its grant.
- **Read-after-write:** req0 writes 0xDEADBEEF to address 10, then reads address 10 in the next cycle -> second response rdata = 0xDEADBEEF, err=0.
- **Out of range:** req1 reads address 251 -> `gnt1`=1, `mem_read_en`=0; next cycle `rsp1_err`=1, rdata=0. A write to address 300 leaves all 251 locations unchanged.
- **Lock and bound:** req0 holds lock=1 with continuous requests while req1 also requests, LOCK_MAX=4 -> `gnt0` for 4 cycles, `gnt1`=0 throughout, then `gnt1`=1 in cycle 5.
- **Reset mid-access:** assert `rst_n`=0 in the cycle after a granted read -> no `rsp` appears; after release, state is FREE and requester 0 wins the next contention.
